// File: rtl/img_pkg.sv
// Definitions shared by the image frame reader and writer.
package img_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WR,
        RUN,
        DRAIN
    } state_t;

    // Reader and writer both size the BRAM address bus with this function.
    function automatic int ADDR_W(input int width, input int height);
        return $clog2(width * height) + 1;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry skid FIFO. The head entry drives the outputs directly from a
// register, and the second entry absorbs one extra word while the head is stalled.
module stream_skid_fifo #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count
);

    logic [DW-1:0] head_q;
    logic [DW-1:0] skid_q;
    logic [1:0]    count_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= din;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= din;
                    end else if (push) begin
                        skid_q  <= din;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= skid_q;
                        if (push) skid_q <= din;
                        else      count_q <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign dout  = head_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

endmodule

// File: rtl/img_stream_reader.sv
// Frame read-out engine: scans the image BRAM and emits pixels as a video
// stream, with a start-of-frame tag (tuser) and an end-of-line tag (tlast).
module img_stream_reader
    import img_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int BIT_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              start,
    input  logic                              wr_busy,
    output logic [ADDR_W(WIDTH, HEIGHT)-1:0]  r_addr,
    output logic                              r_en,
    input  logic [BIT_WIDTH-1:0]              r_data,
    output logic [BIT_WIDTH-1:0]              m_tdata,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic                              m_tuser,
    output logic                              m_tlast,
    output logic                              busy,
    output logic                              done
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int AW = ADDR_W(WIDTH, HEIGHT);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);

    state_t          state_q, state_d;
    logic            start_prev_q;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            inflight_q;
    logic            tag_user_q, tag_last_q;
    logic            done_q;

    logic            start_flag, issue, pop, last_issue, last_pop;
    logic            fifo_push, fifo_full, fifo_empty;
    logic [1:0]      fifo_count;
    logic [2:0]      credit;
    logic [BIT_WIDTH+1:0] fifo_dout;

    assign start_flag = start & ~start_prev_q;
    assign pop        = m_tvalid & m_tready;

    // A beat leaving this cycle frees a slot, so a full-rate stream keeps issuing.
    assign credit     = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issue      = (state_q == RUN) && (credit < 3'd2);
    assign last_issue = issue && (addr_q == AW'(N - 1));
    assign last_pop   = (state_q == DRAIN) && pop && !inflight_q && (fifo_count == 2'd1);
    assign fifo_push  = inflight_q && (!fifo_full || pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_flag) state_d = wr_busy ? WAIT_WR : RUN;
            WAIT_WR: if (!wr_busy)   state_d = RUN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:   if (last_pop)   state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        col_d  = col_q;
        row_d  = row_q;
        if (issue) begin
            if (addr_q == AW'(N - 1)) begin
                addr_d = '0;
                col_d  = '0;
                row_d  = '0;
            end else begin
                addr_d = addr_q + AW'(1);
                if (col_q == CW'(WIDTH - 1)) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            addr_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            inflight_q   <= 1'b0;
            tag_user_q   <= 1'b0;
            tag_last_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start;
            addr_q       <= addr_d;
            col_q        <= col_d;
            row_q        <= row_d;
            inflight_q   <= issue;
            // Tags are captured alongside the read so they meet their data word.
            tag_user_q   <= (col_q == '0) && (row_q == '0);
            tag_last_q   <= (col_q == CW'(WIDTH - 1));
            done_q       <= last_pop;
        end
    end

    stream_skid_fifo #(
        .DW(BIT_WIDTH + 2)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (fifo_push),
        .din   ({tag_user_q, tag_last_q, r_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {m_tuser, m_tlast, m_tdata} = fifo_dout;
    assign m_tvalid = ~fifo_empty;
    assign r_en     = issue;
    assign r_addr   = addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_img_stream_reader.sv
// Directed bench for img_stream_reader on a 4x3 frame with BRAM data = address.
module tb_img_stream_reader;

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       l;
    } pix_t;

    typedef struct {
        int pct;
        int wait_c;
        int dbl;
        int abort_at;
        int e_ren;
        int e_valid;
        int e_done;
    } vec_t;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic       wr_busy;
    logic [4:0] r_addr;
    logic       r_en;
    logic [7:0] r_data;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tuser;
    logic       m_tlast;
    logic       busy;
    logic       done;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    pix_t got[$];
    pix_t exp_pix[12];
    vec_t vecs[7];

    img_stream_reader #(
        .WIDTH(4),
        .HEIGHT(3),
        .BIT_WIDTH(8)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .wr_busy  (wr_busy),
        .r_addr   (r_addr),
        .r_en     (r_en),
        .r_data   (r_data),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tuser  (m_tuser),
        .m_tlast  (m_tlast),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // BRAM model: registered read, contents equal to address.
    initial begin
        r_data = '0;
        forever begin
            @(posedge clk);
            if (r_en) r_data <= 8'(r_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: collects handshakes, checks address order, stall stability, occupancy.
    initial begin
        int   issued;
        int   hs;
        int   exp_addr;
        logic prev_stall;
        pix_t prev_pix;
        issued = 0; hs = 0; exp_addr = 0; prev_stall = 1'b0; prev_pix = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                issued = 0; hs = 0; exp_addr = 0; prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid_held", m_tvalid, 1);
                    chk("stall_beat_held", {m_tdata, m_tuser, m_tlast}, prev_pix);
                end
                if (busy) chk("fifo_occupancy_le_2", (issued - hs <= 2), 1);
                if (r_en) begin
                    chk("r_addr_sequence", r_addr, exp_addr);
                    exp_addr = (exp_addr + 1) % 12;
                    issued++;
                end
                if (m_tvalid && m_tready) begin
                    got.push_back({m_tdata, m_tuser, m_tlast});
                    hs++;
                end
                prev_stall = m_tvalid && !m_tready;
                prev_pix   = {m_tdata, m_tuser, m_tlast};
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_r_addr"},   r_addr,   0);
        chk({tag, "_r_en"},     r_en,     0);
        chk({tag, "_m_tvalid"}, m_tvalid, 0);
        chk({tag, "_m_tdata"},  m_tdata,  0);
        chk({tag, "_m_tuser"},  m_tuser,  0);
        chk({tag, "_m_tlast"},  m_tlast,  0);
        chk({tag, "_busy"},     busy,     0);
        chk({tag, "_done"},     done,     0);
    endtask

    task automatic run_frame(input vec_t v);
        int k;
        int first_ren;
        int first_valid;
        int done_lat;
        bit ended;
        first_ren = -1; first_valid = -1; done_lat = -1; ended = 0;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        got.delete();
        start    = 1'b1;
        wr_busy  = (v.wait_c > 0);
        m_tready = (v.pct == 100) ? 1'b1 : 1'($urandom_range(0, 1));
        k = cyc + 1;
        for (int t = 0; t < 200 && !ended; t++) begin
            @(posedge clk); #1;
            if (t == 0) chk("busy_after_start", busy, 1);
            if (cyc < k + v.wait_c) chk("no_read_while_wr_busy", r_en, 0);
            if (r_en && first_ren < 0) first_ren = cyc - k;
            if (m_tvalid && first_valid < 0) first_valid = cyc - k;
            if (v.abort_at >= 0 && m_tvalid && m_tdata == 8'(v.abort_at)) begin
                m_tready = 1'b0;
                n_rst    = 1'b0;
                ended    = 1;
            end else if (done) begin
                done_lat = cyc - k;
                chk("busy_falls_with_done", busy, 0);
                ended = 1;
                if (v.dbl == 0) start = 1'b0;
            end else begin
                if (v.wait_c > 0 && cyc == k + v.wait_c - 1) wr_busy = 1'b0;
                if (v.dbl != 0 && cyc == k + 3) start = 1'b0;
                if (v.dbl != 0 && cyc == k + 5) start = 1'b1;
                m_tready = (v.pct == 100) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
        if (!ended) chk("frame_timeout", 0, 1);
        chk("first_read_latency", first_ren, v.e_ren);
        chk("first_valid_latency", first_valid, v.e_valid);
        if (v.e_done >= 0) chk("done_latency", done_lat, v.e_done);
        if (v.abort_at < 0) begin
            chk("pixel_count", got.size(), 12);
            for (int i = 0; i < 12 && i < got.size(); i++)
                chk($sformatf("pixel_%0d", i), got[i], exp_pix[i]);
        end
    endtask

    initial begin
        logic activity;
        exp_pix = '{
            '{8'd0,  1'b1, 1'b0}, '{8'd1,  1'b0, 1'b0}, '{8'd2,  1'b0, 1'b0}, '{8'd3,  1'b0, 1'b1},
            '{8'd4,  1'b0, 1'b0}, '{8'd5,  1'b0, 1'b0}, '{8'd6,  1'b0, 1'b0}, '{8'd7,  1'b0, 1'b1},
            '{8'd8,  1'b0, 1'b0}, '{8'd9,  1'b0, 1'b0}, '{8'd10, 1'b0, 1'b0}, '{8'd11, 1'b0, 1'b1}
        };
        //          pct wait dbl abort ren valid done
        vecs[0] = '{100, 0,  0,  -1,   0,  2,    14};
        vecs[1] = '{50,  0,  0,  -1,   0,  2,    -1};
        vecs[2] = '{100, 10, 0,  -1,   10, 12,   24};
        vecs[3] = '{100, 0,  1,  -1,   0,  2,    14};
        vecs[4] = '{100, 0,  0,  5,    0,  2,    -1};
        vecs[5] = '{100, 0,  0,  -1,   0,  2,    14};
        vecs[6] = '{100, 0,  0,  -1,   0,  2,    14};

        n_rst = 1'b0; start = 1'b0; wr_busy = 1'b0; m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        n_rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i]);
            if (vecs[i].abort_at >= 0) begin
                @(posedge clk); #1;
                check_reset_vals("abort");
                @(posedge clk); #1;
                n_rst = 1'b1;
                start = 1'b0;
            end
            if (vecs[i].dbl != 0) begin
                activity = 1'b0;
                repeat (20) begin
                    @(posedge clk); #1;
                    activity = activity | busy | done | r_en | m_tvalid;
                end
                chk("no_frame_while_start_held", activity, 0);
                chk("pixels_after_hold", got.size(), 12);
                start = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/img_stream_reader.md
# img_stream_reader

Frame read-out engine for the image BRAM. On a start request it scans addresses 0 to WIDTH*HEIGHT-1 through the memory's read port and emits the pixels as an AXI4-Stream-style video stream with start-of-frame and end-of-line markers. It is the read-side counterpart of the frame writer. It honours downstream backpressure without losing or duplicating pixels, and never starts a scan while the memory is being written.

## Interface
Parameters:
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- BIT_WIDTH, 8, bits per pixel

Ports:
- clk  in  1  clock
- n_rst  in  1  reset n_rst, synchronous, active-low; clock clk
- start  in  1  read request (level); its rising edge starts a frame scan
- wr_busy  in  1  memory write in progress (writer's busy flag)
- r_addr  out  $clog2(WIDTH*HEIGHT)+1  memory read address
- r_en  out  1  read enable for the memory read port
- r_data  in  BIT_WIDTH  memory read data, valid one cycle after r_en/r_addr are sampled
- m_tdata  out  BIT_WIDTH  pixel
- m_tvalid  out  1  pixel valid
- m_tready  in  1  downstream ready
- m_tuser  out  1  start of frame; high only with pixel 0
- m_tlast  out  1  end of line; high on column WIDTH-1
- busy  out  1  scan in progress (all states except IDLE)
- done  out  1  one-cycle pulse after the final pixel handshake

## Operation
- Start detection: register start_prev; start_flag = start & !start_prev. Rising edges seen outside IDLE are ignored.
- FSM states:
  - IDLE: on start_flag, go to WAIT_WR if wr_busy, else to RUN.
  - WAIT_WR: go to RUN when wr_busy = 0.
  - RUN: issue reads. After the read of address WIDTH*HEIGHT-1 is issued, go to DRAIN.
  - DRAIN: when the last pixel handshakes, pulse done and go to IDLE.
- Read issue: r_en = 1 in RUN only when (buffer occupancy + reads in flight) < 2. r_addr increments on each issued read.
- Output buffer: 2-entry FIFO (skid). Every returned r_data word is written into it, together with its tuser/tlast tags.
- Handshake: a transfer occurs when m_tvalid & m_tready. While m_tvalid=1 and m_tready=0, m_tdata, m_tuser and m_tlast hold stable.
- Tags: a column counter (0..WIDTH-1) and a row counter (0..HEIGHT-1) advance on each issued read.
  - tlast = (col == WIDTH-1).
  - tuser = (col == 0 && row == 0).
  - Tags travel through the pipeline with the data.
- Wrap: after the last issue, r_addr, col and row return to 0.
- wr_busy rising during RUN or DRAIN has no effect. Caller-level protocol forbids this case.
- Reset: all state cleared, FSM to IDLE, FIFO emptied, any in-flight read discarded.
  - Reset values: r_addr=0, r_en=0, m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, busy=0, done=0.
  - A reset in the middle of a frame aborts the frame; the next start begins again at pixel 0.

## Timing
- start_flag sampled at edge k (wr_busy=0) puts the FSM in RUN after edge k, with r_en=1 and r_addr=0 during cycle k..k+1.
- Memory data is available after edge k+1. It enters the FIFO at edge k+2.
- m_tvalid=1 from edge k+2. Latency from the start edge to the first valid pixel is 2 cycles.
- With m_tready held at 1: one pixel per clock, and a full frame takes WIDTH*HEIGHT+2 cycles from edge k until done.
- When m_tready drops, at most 2 words are outstanding. Both are absorbed by the FIFO; no overflow occurs.
- done is high for the cycle after the final handshake edge. busy falls at the same edge. A new start_flag is accepted at the next edge.

## Structure
- Shared package img_pkg holds:
  - ADDR_W(WIDTH, HEIGHT) width function (shared with the writer, so both use the same address width)
  - FSM state enum (IDLE, WAIT_WR, RUN, DRAIN)
- Sub-module stream_skid_fifo: 2-entry FIFO, parameterised on data width, carrying {tuser, tlast, tdata}. Outputs registered, with full/empty and a count.
- Top level contains the FSM, address/column/row counters, the in-flight tracking bit, and the edge detector.

## Test plan
- Basic frame, WIDTH=4, HEIGHT=3, memory preloaded with data = address, m_tready=1:
  - 12 pixels 0..11 on consecutive cycles
  - tuser on pixel 0 only; tlast on pixels 3, 7, 11
  - first m_tvalid 2 cycles after the start edge; done 1 cycle after pixel 11
- Random m_tready (50%): pixel sequence identical to the basic case; tdata/tuser/tlast stable while stalled; r_en never pushes the FIFO past 2 entries.
- start asserted while wr_busy=1 for 10 cycles: r_en stays 0 during those cycles; the first read (r_addr=0) is issued the cycle after wr_busy falls.
- Second start edge during RUN: ignored; exactly 12 pixels emitted. start held high after done: no new frame until start falls and rises again.
- n_rst asserted at pixel 5 with m_tready=0:
  - all outputs go to their reset values the next cycle
  - a subsequent start yields pixel 0 with tuser=1 and a complete 12-pixel frame
- Back-to-back frames: start toggled immediately after done; the second frame is identical and r_addr wraps from 11 to 0.
